// File: rtl/mtimer_access_ctrl_if.sv
// Requester-side bus of the mtimer access controller: one request/ack
// handshake with latched-on-grant command fields and held read data.
interface mtimer_access_ctrl_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            req;
    logic            we;
    logic [1:0]      addr;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ack,
        output rdata
    );
endinterface

// File: rtl/mtimer_access_ctrl.sv
// Round-robin access controller between cpu and dbg requesters and the machine
// timer, with glitch-free 64-bit mtimecmp updates through a staged high word.
module mtimer_access_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sync_reset,
    mtimer_access_ctrl_if.slave   cpu,
    mtimer_access_ctrl_if.slave   dbg,
    output logic                  load_mtimecmp_low,
    output logic                  load_mtimecmp_high,
    output logic [XLEN-1:0]       mtimecmp_write_data,
    output logic [1:0]            reg_read_addr,
    input  logic [XLEN-1:0]       reg_read_data,
    output logic                  busy
);

    localparam int unsigned AW = 2;
    localparam logic [AW-1:0] ADDR_MTIME_LO = 2'b00;
    localparam logic [AW-1:0] ADDR_CMP_LO   = 2'b10;
    localparam logic [AW-1:0] ADDR_CMP_HI   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_CAP,
        WR_MAX,
        WR_LOW,
        WR_HIGH,
        WR_NOP
    } state_t;

    state_t          state_q, state_d;

    logic            last_dbg_q;
    logic            gnt_dbg_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] wdata_q;

    logic [XLEN-1:0] stg_cpu_q, stg_dbg_q;
    logic            stg_vld_cpu_q, stg_vld_dbg_q;

    logic            cpu_ack_q, dbg_ack_q;
    logic [XLEN-1:0] cpu_rdata_q, dbg_rdata_q;
    logic            load_low_q, load_high_q;
    logic [XLEN-1:0] cmp_wdata_q;
    logic [AW-1:0]   rd_addr_q;
    logic            busy_q;

    logic            grant_c;
    logic            pick_dbg_c;
    logic            op_we_c;
    logic [AW-1:0]   op_addr_c;
    logic [XLEN-1:0] op_wdata_c;
    logic            staged_sel_c;
    logic [XLEN-1:0] staged_val_c;
    logic            ack_fire_c;
    logic            rd_active_c;

    // Next-state logic; in IDLE the live winner's inputs stand in for the latches
    always_comb begin
        state_d    = state_q;
        grant_c    = 1'b0;
        pick_dbg_c = gnt_dbg_q;
        op_we_c    = we_q;
        op_addr_c  = addr_q;
        op_wdata_c = wdata_q;

        if (state_q == IDLE) begin
            grant_c    = cpu.req || dbg.req;
            pick_dbg_c = dbg.req && (!cpu.req || !last_dbg_q);
            op_we_c    = pick_dbg_c ? dbg.we    : cpu.we;
            op_addr_c  = pick_dbg_c ? dbg.addr  : cpu.addr;
            op_wdata_c = pick_dbg_c ? dbg.wdata : cpu.wdata;
        end

        staged_sel_c = pick_dbg_c ? stg_vld_dbg_q : stg_vld_cpu_q;
        staged_val_c = pick_dbg_c ? stg_dbg_q     : stg_cpu_q;

        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    if (!op_we_c) begin
                        state_d = RD_ISSUE;
                    end else if (op_addr_c == ADDR_CMP_LO) begin
                        state_d = staged_sel_c ? WR_MAX : WR_LOW;
                    end else begin
                        state_d = WR_NOP;
                    end
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = RD_CAP;
            RD_CAP:   state_d = IDLE;
            WR_MAX:   state_d = WR_LOW;
            WR_LOW:   state_d = staged_sel_c ? WR_HIGH : IDLE;
            WR_HIGH:  state_d = IDLE;
            WR_NOP:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // A WR_LOW entered straight from IDLE is a plain low write and acks itself
        ack_fire_c = (state_d == RD_CAP) || (state_d == WR_NOP) || (state_d == WR_HIGH) ||
                     ((state_d == WR_LOW) && (state_q == IDLE));
        rd_active_c = (state_d == RD_ISSUE) || (state_d == RD_WAIT) || (state_d == RD_CAP);
    end

    // State register, arbitration pointer and latched command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_dbg_q <= 1'b1;
            gnt_dbg_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (sync_reset) begin
            state_q    <= IDLE;
            last_dbg_q <= 1'b1;
            gnt_dbg_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (grant_c) begin
                last_dbg_q <= pick_dbg_c;
                gnt_dbg_q  <= pick_dbg_c;
                we_q       <= op_we_c;
                addr_q     <= op_addr_c;
                wdata_q    <= op_wdata_c;
            end
        end
    end

    // Per-requester staged mtimecmp high word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_cpu_q     <= '0;
            stg_dbg_q     <= '0;
            stg_vld_cpu_q <= 1'b0;
            stg_vld_dbg_q <= 1'b0;
        end else if (sync_reset) begin
            stg_cpu_q     <= '0;
            stg_dbg_q     <= '0;
            stg_vld_cpu_q <= 1'b0;
            stg_vld_dbg_q <= 1'b0;
        end else begin
            if ((state_d == WR_NOP) && op_we_c && (op_addr_c == ADDR_CMP_HI)) begin
                if (pick_dbg_c) begin
                    stg_dbg_q     <= op_wdata_c;
                    stg_vld_dbg_q <= 1'b1;
                end else begin
                    stg_cpu_q     <= op_wdata_c;
                    stg_vld_cpu_q <= 1'b1;
                end
            end
            if (state_d == WR_HIGH) begin
                if (pick_dbg_c) begin
                    stg_vld_dbg_q <= 1'b0;
                end else begin
                    stg_vld_cpu_q <= 1'b0;
                end
            end
        end
    end

    // Registered outputs, computed from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            load_low_q  <= 1'b0;
            load_high_q <= 1'b0;
            cmp_wdata_q <= '0;
            rd_addr_q   <= ADDR_MTIME_LO;
            busy_q      <= 1'b0;
        end else if (sync_reset) begin
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            load_low_q  <= 1'b0;
            load_high_q <= 1'b0;
            cmp_wdata_q <= '0;
            rd_addr_q   <= ADDR_MTIME_LO;
            busy_q      <= 1'b0;
        end else begin
            cpu_ack_q   <= ack_fire_c && !pick_dbg_c;
            dbg_ack_q   <= ack_fire_c && pick_dbg_c;
            load_low_q  <= (state_d == WR_LOW);
            load_high_q <= (state_d == WR_MAX) || (state_d == WR_HIGH);
            busy_q      <= (state_d != IDLE);
            // Park on mtime low while idle so the timer's high snapshot keeps refreshing
            rd_addr_q   <= rd_active_c ? op_addr_c : ADDR_MTIME_LO;

            if (state_d == RD_CAP) begin
                if (pick_dbg_c) begin
                    dbg_rdata_q <= reg_read_data;
                end else begin
                    cpu_rdata_q <= reg_read_data;
                end
            end

            case (state_d)
                WR_MAX:  cmp_wdata_q <= '1;
                WR_LOW:  cmp_wdata_q <= op_wdata_c;
                WR_HIGH: cmp_wdata_q <= staged_val_c;
                default: cmp_wdata_q <= cmp_wdata_q;
            endcase
        end
    end

    assign cpu.ack             = cpu_ack_q;
    assign dbg.ack             = dbg_ack_q;
    assign cpu.rdata           = cpu_rdata_q;
    assign dbg.rdata           = dbg_rdata_q;
    assign load_mtimecmp_low   = load_low_q;
    assign load_mtimecmp_high  = load_high_q;
    assign mtimecmp_write_data = cmp_wdata_q;
    assign reg_read_addr       = rd_addr_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_mtimer_access_ctrl.sv
// Randomized self-checking bench for mtimer_access_ctrl with a simple timer
// model and a transaction-level reference model of registers and staging.
module tb_mtimer_access_ctrl;

    localparam int unsigned XLEN = 32;
    localparam logic [63:0] MTIME = 64'h0000_00AB_CDEF_0123;

    logic clk = 1'b0;
    logic reset;
    logic sync_reset;
    logic load_lo, load_hi;
    logic [XLEN-1:0] cmp_wd;
    logic [1:0] rd_addr;
    logic [XLEN-1:0] rd_data;
    logic busy;

    mtimer_access_ctrl_if #(.XLEN(XLEN)) cpu_if ();
    mtimer_access_ctrl_if #(.XLEN(XLEN)) dbg_if ();

    mtimer_access_ctrl #(.XLEN(XLEN)) dut (
        .clk                 (clk),
        .reset               (reset),
        .sync_reset          (sync_reset),
        .cpu                 (cpu_if),
        .dbg                 (dbg_if),
        .load_mtimecmp_low   (load_lo),
        .load_mtimecmp_high  (load_hi),
        .mtimecmp_write_data (cmp_wd),
        .reg_read_addr       (rd_addr),
        .reg_read_data       (rd_data),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Timer: registered read port, mtimecmp loaded by strobes, mtime frozen
    logic [63:0] tmr_cmp = 64'h0;
    always @(posedge clk) begin
        if (load_lo) tmr_cmp[31:0] <= cmp_wd;
        if (load_hi) tmr_cmp[63:32] <= cmp_wd;
        case (rd_addr)
            2'b00:   rd_data <= MTIME[31:0];
            2'b01:   rd_data <= MTIME[63:32];
            2'b10:   rd_data <= tmr_cmp[31:0];
            default: rd_data <= tmr_cmp[63:32];
        endcase
        cyc <= cyc + 1;
    end

    // Strobe log and always-on exclusivity checks
    logic [32:0] strb_q[$];
    int strb_cyc[$];
    always @(negedge clk) begin
        checks++;
        if (load_lo && load_hi) begin
            errors++;
            $display("FAIL strobe_exclusive: low=%b high=%b, required at most one", load_lo, load_hi);
        end
        checks++;
        if (cpu_if.ack && dbg_if.ack) begin
            errors++;
            $display("FAIL ack_exclusive: cpu_ack=%b dbg_ack=%b, required not both", cpu_if.ack, dbg_if.ack);
        end
        if (load_lo || load_hi) begin
            strb_q.push_back({load_hi, cmp_wd});
            strb_cyc.push_back(cyc);
        end
    end

    // Reference model
    logic [63:0] m_cmp = 64'h0;
    logic        m_stg_v[2];
    logic [31:0] m_stg[2];
    logic [31:0] m_rdata[2];

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'b00:   return MTIME[31:0];
            2'b01:   return MTIME[63:32];
            2'b10:   return m_cmp[31:0];
            default: return m_cmp[63:32];
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_stg_v[i] = 1'b0;
            m_stg[i]   = '0;
            m_rdata[i] = '0;
        end
    endtask

    task automatic drive(input int who, input logic req, input logic we, input logic [1:0] a,
                         input logic [31:0] wd);
        if (who == 0) begin
            cpu_if.req = req; cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = wd;
        end else begin
            dbg_if.req = req; dbg_if.we = we; dbg_if.addr = a; dbg_if.wdata = wd;
        end
    endtask

    // One transaction; called #1 after a posedge with the DUT idle, returns likewise
    task automatic do_op(input int who, input logic we, input logic [1:0] a, input logic [31:0] wd,
                         input string tag);
        logic [32:0] exp_s[$];
        int exp_lat, lat, ack_cyc;
        logic [31:0] exp_rd, rd;
        logic got, busy_ack, ok;
        exp_rd = m_rdata[who];
        exp_lat = 1;
        if (!we) begin
            exp_lat = 3;
            exp_rd = m_reg(a);
        end else if (a == 2'b11) begin
            m_stg[who] = wd;
            m_stg_v[who] = 1'b1;
        end else if (a == 2'b10) begin
            if (m_stg_v[who]) begin
                exp_lat = 3;
                exp_s.push_back({1'b1, 32'hFFFF_FFFF});
                exp_s.push_back({1'b0, wd});
                exp_s.push_back({1'b1, m_stg[who]});
                m_cmp = {m_stg[who], wd};
                m_stg_v[who] = 1'b0;
            end else begin
                exp_s.push_back({1'b0, wd});
                m_cmp[31:0] = wd;
            end
        end
        m_rdata[who] = exp_rd;

        strb_q.delete();
        strb_cyc.delete();
        drive(who, 1'b1, we, a, wd);
        lat = 0;
        got = 1'b0;
        ack_cyc = 0;
        while (!got && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
            got = (who == 0) ? cpu_if.ack : dbg_if.ack;
            // Command fields are don't-care once granted
            if (!got) drive(who, 1'b1, 1'($urandom), 2'($urandom), $urandom);
        end
        ack_cyc = cyc;
        busy_ack = busy;
        rd = (who == 0) ? cpu_if.rdata : dbg_if.rdata;
        drive(who, 1'b0, 1'b0, 2'b00, 32'h0);

        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, required %0d", tag, lat, exp_lat);
        end
        checks++;
        if (rd !== exp_rd) begin
            errors++;
            $display("FAIL %s rdata: got %h, required %h", tag, rd, exp_rd);
        end
        checks++;
        if (busy_ack !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_at_ack: got %b, required 1", tag, busy_ack);
        end

        @(posedge clk);
        #1;
        checks++;
        if ({busy, cpu_if.ack, dbg_if.ack} !== 3'b000) begin
            errors++;
            $display("FAIL %s after_ack: busy/cpu_ack/dbg_ack=%b, required 000", tag,
                     {busy, cpu_if.ack, dbg_if.ack});
        end
        ok = (strb_q.size() == exp_s.size());
        for (int i = 0; ok && i < exp_s.size(); i++) begin
            if (strb_q[i] !== exp_s[i]) ok = 1'b0;
            if (strb_cyc[i] != ack_cyc - exp_s.size() + 1 + i) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s strobes: got %0d strobes (first %h), required %0d (first %h)", tag,
                     strb_q.size(), (strb_q.size() > 0) ? strb_q[0] : 33'h0, exp_s.size(),
                     (exp_s.size() > 0) ? exp_s[0] : 33'h0);
        end
    endtask

    task automatic check_quiet(input string tag);
        checks++;
        if ({cpu_if.ack, dbg_if.ack, load_lo, load_hi, busy} !== 5'b0) begin
            errors++;
            $display("FAIL %s ctrl: ack/ack/lo/hi/busy=%b, required 00000", tag,
                     {cpu_if.ack, dbg_if.ack, load_lo, load_hi, busy});
        end
        checks++;
        if ({cpu_if.rdata, dbg_if.rdata, cmp_wd} !== '0) begin
            errors++;
            $display("FAIL %s data: cpu_rdata=%h dbg_rdata=%h wdata=%h, required 0", tag,
                     cpu_if.rdata, dbg_if.rdata, cmp_wd);
        end
        checks++;
        if (rd_addr !== 2'b00) begin
            errors++;
            $display("FAIL %s reg_read_addr: got %b, required 00", tag, rd_addr);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_held");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_quiet("reset_released");
    endtask

    task automatic test_arbitration();
        int order[$];
        logic cd, dd;
        int n;
        logic [1:0] ac, ad;
        logic [31:0] ec, ed;
        for (int r = 0; r < 2; r++) begin
            ac = 2'($urandom);
            ad = 2'($urandom);
            ec = m_reg(ac);
            ed = m_reg(ad);
            drive(0, 1'b1, 1'b0, ac, 32'h0);
            drive(1, 1'b1, 1'b0, ad, 32'h0);
            cd = 1'b0;
            dd = 1'b0;
            n = 0;
            while (!(cd && dd) && n < 20) begin
                @(posedge clk);
                #1;
                n++;
                if (cpu_if.ack && !cd) begin
                    order.push_back(0);
                    cd = 1'b1;
                    checks++;
                    if (cpu_if.rdata !== ec) begin
                        errors++;
                        $display("FAIL arb_cpu_rdata: got %h, required %h", cpu_if.rdata, ec);
                    end
                    drive(0, 1'b0, 1'b0, 2'b00, 32'h0);
                end
                if (dbg_if.ack && !dd) begin
                    order.push_back(1);
                    dd = 1'b1;
                    checks++;
                    if (dbg_if.rdata !== ed) begin
                        errors++;
                        $display("FAIL arb_dbg_rdata: got %h, required %h", dbg_if.rdata, ed);
                    end
                    drive(1, 1'b0, 1'b0, 2'b00, 32'h0);
                end
            end
            m_rdata[0] = ec;
            m_rdata[1] = ed;
            drive(0, 1'b0, 1'b0, 2'b00, 32'h0);
            drive(1, 1'b0, 1'b0, 2'b00, 32'h0);
            @(posedge clk);
            #1;
        end
        checks++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1)
        begin
            errors++;
            $display("FAIL arb_order: got %0d grants %p, required cpu,dbg,cpu,dbg", order.size(), order);
        end
    endtask

    task automatic test_read();
        do_op(0, 1'b1, 2'b10, 32'h0000_0100, "load_cmp_lo");
        do_op(0, 1'b0, 2'b10, 32'h0, "read_cmp_lo");
        do_op(1, 1'b0, 2'b01, 32'h0, "read_mtime_hi");
    endtask

    task automatic test_staged_write();
        do_op(0, 1'b1, 2'b11, 32'h0000_0001, "stage_hi");
        do_op(0, 1'b1, 2'b10, 32'h0000_0020, "three_step");
        do_op(0, 1'b0, 2'b11, 32'h0, "read_cmp_hi");
        do_op(0, 1'b1, 2'b10, 32'h0000_0021, "after_stage_plain");
    endtask

    task automatic test_plain_low();
        do_op(0, 1'b1, 2'b10, 32'h0000_0055, "plain_low");
    endtask

    task automatic test_private_staging();
        do_op(1, 1'b1, 2'b11, 32'h0000_0007, "dbg_stage");
        do_op(0, 1'b1, 2'b10, 32'h0000_0009, "cpu_low_private");
        do_op(1, 1'b1, 2'b10, 32'h0000_000A, "dbg_three_step");
    endtask

    task automatic test_readonly_write();
        do_op(0, 1'b1, 2'b00, $urandom, "wr_mtime_lo");
        do_op(1, 1'b1, 2'b01, $urandom, "wr_mtime_hi");
        do_op(0, 1'b0, 2'b00, 32'h0, "read_mtime_lo");
    endtask

    task automatic test_reset_mid();
        int n;
        do_op(0, 1'b1, 2'b11, 32'h0000_0042, "mid_stage");
        strb_q.delete();
        drive(0, 1'b1, 1'b1, 2'b10, 32'h0000_1234);
        n = 0;
        while (!load_lo && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!load_lo) begin
            errors++;
            $display("FAIL mid_reset_reach_low: low strobe got %b, required 1", load_lo);
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0);
        #1;
        check_quiet("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (strb_q.size() != 2 || strb_q[0] !== {1'b1, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL mid_reset_strobes: got %0d strobes, required 2 (max high, low)", strb_q.size());
        end
        // Low strobe was cut off before the timer's sampling edge
        m_cmp[63:32] = 32'hFFFF_FFFF;
        model_reset();
        do_op(0, 1'b0, 2'b11, 32'h0, "post_reset_cmp_hi");
        do_op(0, 1'b0, 2'b10, 32'h0, "post_reset_cmp_lo");
        do_op(0, 1'b1, 2'b10, 32'h0000_0abc, "post_reset_plain");
    endtask

    task automatic test_sync_reset();
        int n;
        do_op(1, 1'b1, 2'b11, 32'h0000_0077, "sync_stage");
        strb_q.delete();
        drive(1, 1'b1, 1'b1, 2'b10, 32'h0000_0088);
        n = 0;
        while (!load_hi && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        sync_reset = 1'b1;
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0);
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        check_quiet("sync_reset");
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (strb_q.size() != 1) begin
            errors++;
            $display("FAIL sync_reset_strobes: got %0d strobes, required 1", strb_q.size());
        end
        m_cmp[63:32] = 32'hFFFF_FFFF;
        model_reset();
        do_op(1, 1'b0, 2'b11, 32'h0, "sync_cmp_hi");
        do_op(1, 1'b1, 2'b10, 32'h0000_0099, "sync_plain");
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            do_op(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), $urandom, "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        sync_reset = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0);
        model_reset();
        test_reset();
        test_arbitration();
        test_read();
        test_staged_write();
        test_plain_low();
        test_private_staging();
        test_readonly_write();
        test_reset_mid();
        test_sync_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
